// File: rtl/lsu_mem_master.sv
// Load/store initiator to a word-organised data memory.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic                  we_q;
  logic                  uns_q;
  logic                  err_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  accept;
  logic                  mis;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ext;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || mis;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch at acceptance and read-data capture in READ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        idx_q   <= req_addr[ADDR_WIDTH+1:2];
        wdata_q <= req_wdata;
      end
      if (state == READ) data_q <= mem_rd;
    end
  end

  // Next-state logic and FSM-driven outputs
  always_comb begin
    state_nx   = state;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)
            state_nx = RESP;
          else if (req_we && (req_size == 2'b10))
            state_nx = WRITE;
          else
            state_nx = READ;
        end
      end
      READ: state_nx = we_q ? WRITE : RESP;
      WRITE: begin
        mem_we   = rst_n;
        mem_wd   = (size_q == 2'b10) ? wdata_q : merged;
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = ext;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr = idx_q;

  // Lane merge for sub-word stores and load extension
  always_comb begin
    merged = data_q;
    ext    = data_q;
    lb     = data_q[8*off_q +: 8];
    lh     = data_q[16*off_q[1] +: 16];
    unique case (size_q)
      2'b00: begin
        merged[8*off_q +: 8] = wdata_q[7:0];
        ext = {{24{lb[7] & ~uns_q}}, lb};
      end
      2'b01: begin
        merged[16*off_q[1] +: 16] = wdata_q[15:0];
        ext = {{16{lh[15] & ~uns_q}}, lh};
      end
      default: begin
        merged = data_q;
        ext    = data_q;
      end
    endcase
  end

endmodule
